// File: rtl/frontend_packet_arbiter_if.sv
// rtl/frontend_packet_arbiter_if.sv - stream bundle between the packet sources, the arbiter and the link FIFO
interface frontend_packet_arbiter_if #(
  parameter int NUM_BLOCKS = 4,
  parameter int SRC_W      = 3
);
  logic                      enable;
  logic                      tt_valid;
  logic                      tt_ready;
  logic [127:0]              tt;
  logic [NUM_BLOCKS-1:0]     ev_valid;
  logic [NUM_BLOCKS-1:0]     ev_ready;
  logic [128*NUM_BLOCKS-1:0] ev_data;
  logic                      m_valid;
  logic                      m_ready;
  logic [127:0]              m_data;
  logic                      m_is_tt;
  logic [SRC_W-1:0]          m_block;
  logic [31:0]               pkt_count;

  // The environment that drives the sources and sinks the output stream.
  modport master (
    output enable, tt_valid, tt, ev_valid, ev_data, m_ready,
    input  tt_ready, ev_ready, m_valid, m_data, m_is_tt, m_block, pkt_count
  );

  modport slave (
    input  enable, tt_valid, tt, ev_valid, ev_data, m_ready,
    output tt_ready, ev_ready, m_valid, m_data, m_is_tt, m_block, pkt_count
  );
endinterface

// File: rtl/frontend_packet_arbiter.sv
// rtl/frontend_packet_arbiter.sv - time-tag priority / round-robin event merger into one registered output slot
module frontend_packet_arbiter #(
  parameter int NUM_BLOCKS = 4,
  parameter int SRC_W      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  frontend_packet_arbiter_if.slave bus
);

  logic             m_valid_q, m_valid_d;
  logic [127:0]     m_data_q, m_data_d;
  logic             m_is_tt_q, m_is_tt_d;
  logic [SRC_W-1:0] m_block_q, m_block_d;
  logic [31:0]      pkt_count_q, pkt_count_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             slot_free;
  logic             load;
  logic             ev_found;
  logic [SRC_W-1:0] ev_sel;
  logic [SRC_W:0]   idx;
  logic [127:0]     ev_word;

  // First valid block scanning upward from rr_ptr, modulo NUM_BLOCKS.
  always_comb begin
    ev_found = 1'b0;
    ev_sel   = '0;
    idx      = '0;
    for (int k = 0; k < NUM_BLOCKS; k++) begin
      idx = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
      if (idx >= (SRC_W+1)'(NUM_BLOCKS)) idx = idx - (SRC_W+1)'(NUM_BLOCKS);
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        if (!ev_found && (idx == (SRC_W+1)'(i)) && bus.ev_valid[i]) begin
          ev_found = 1'b1;
          ev_sel   = SRC_W'(i);
        end
      end
    end
  end

  assign ev_word   = bus.ev_data[int'(ev_sel)*128 +: 128];
  assign slot_free = ~m_valid_q | bus.m_ready;
  // rst gating keeps every ready low while reset is held, even though the slot reads as free.
  assign load      = ~rst & bus.enable & slot_free & (bus.tt_valid | ev_found);

  always_comb begin
    bus.tt_ready = load & bus.tt_valid;
    bus.ev_ready = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      bus.ev_ready[i] = load & ~bus.tt_valid & (ev_sel == SRC_W'(i));
    end
  end

  always_comb begin
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_is_tt_d   = m_is_tt_q;
    m_block_d   = m_block_q;
    rr_ptr_d    = rr_ptr_q;
    pkt_count_d = pkt_count_q + {31'd0, m_valid_q & bus.m_ready};
    if (load) begin
      m_valid_d = 1'b1;
      if (bus.tt_valid) begin
        m_data_d  = bus.tt;
        m_is_tt_d = 1'b1;
        m_block_d = '0;
      end else begin
        m_data_d  = ev_word;
        m_is_tt_d = 1'b0;
        m_block_d = ev_sel;
        rr_ptr_d  = (ev_sel == SRC_W'(NUM_BLOCKS-1)) ? '0 : ev_sel + SRC_W'(1);
      end
    end else if (slot_free) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_is_tt_q   <= 1'b0;
      m_block_q   <= '0;
      pkt_count_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_is_tt_q   <= m_is_tt_d;
      m_block_q   <= m_block_d;
      pkt_count_q <= pkt_count_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_is_tt   = m_is_tt_q;
  assign bus.m_block   = m_block_q;
  assign bus.pkt_count = pkt_count_q;

endmodule

// File: doc/frontend_packet_arbiter.md
Name: frontend_packet_arbiter

Overview:
- Merges the single-beat 128-bit time-tag stream and NUM_BLOCKS per-block event streams onto one 128-bit output stream.
- The output stream feeds the frontend's downstream link FIFO.
- Scheduling: time tags have strict priority; event sources are served round-robin.
- Provides a registered output slot, source tagging and a delivered-packet counter.

Parameters:
NUM_BLOCKS, 4, number of event sources; legal range 2..8
SRC_W, 3, width of m_block; must satisfy 2^SRC_W >= NUM_BLOCKS

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
enable  input  1  grant enable; when low, no new packet is accepted
tt_valid  input  1  time-tag packet available
tt_ready  output  1  time-tag packet accepted this cycle
tt  input  128  time-tag packet
ev_valid  input  NUM_BLOCKS  per-block event packet available
ev_ready  output  NUM_BLOCKS  per-block accept
ev_data  input  128*NUM_BLOCKS  block i packet at [128*i+127:128*i]
m_valid  output  1  output packet valid
m_ready  input  1  downstream accept
m_data  output  128  output packet, passed through unmodified
m_is_tt  output  1  current output packet is a time tag
m_block  output  SRC_W  source block index of the current event packet; 0 when m_is_tt=1
pkt_count  output  32  count of packets delivered (m_valid & m_ready)

Behaviour:
- Reset (async assert; deassert synchronous to clk): m_valid=0, m_data=0, m_is_tt=0, m_block=0, pkt_count=0, rr_ptr=0.
  - Any packet held in the output slot is discarded.
  - No ready is asserted while rst=1.
- Slot free condition: slot_free = ~m_valid | m_ready.
- Load condition: load = enable & slot_free & (tt_valid | |ev_valid).
- Winner selection, combinational, evaluated every cycle:
  - tt_valid=1 → winner is the time tag.
  - Otherwise → the first i with ev_valid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_BLOCKS.
- Ready outputs: exactly the winner's ready is asserted, and only when load=1; all other readies are 0.
  - Readies depend combinationally on valids, enable and m_ready.
  - Sources must not make valid depend on ready.
- On load:
  - m_data <= winner data; m_is_tt <= (winner is tt); m_block <= winner index (0 for tt); m_valid <= 1.
- Round-robin pointer:
  - On an event grant, rr_ptr <= (i+1) mod NUM_BLOCKS.
  - On a tt grant, rr_ptr is unchanged.
- If slot_free and load=0: m_valid <= 0, and m_data/m_is_tt/m_block hold their last values.
- If m_valid=1 and m_ready=0: the slot is held stable (all m_* unchanged); no grants.
- Latency: 1 cycle from input valid&ready to m_valid. Throughput: 1 packet/cycle with m_ready held high (back-to-back grants while draining).
- Simultaneous tt_valid and event valids: tt wins; events are delayed one grant; rr_ptr is preserved, so fairness among blocks is unaffected.
- Starvation:
  - Time tags arrive at most once per ms period, so strict priority cannot starve events.
  - With all blocks continuously valid, each block is granted once per NUM_BLOCKS event grants.
- enable low: the packet already in the slot is still delivered; no new grants. When enable rises, arbitration resumes with the retained rr_ptr.
- pkt_count: increments by 1 on each cycle with m_valid & m_ready; wraps from 2^32-1 to 0.
- No packet is duplicated or dropped: every input handshake produces exactly one output handshake, unless reset intervenes.

Test Plan:
- Reset mid-transfer: load a packet with m_ready=0, then pulse rst → m_valid=0 immediately (async), pkt_count=0, no readies; after release, the first grant goes to block 0 if all ev_valid=1.
- Round-robin, all four ev_valid=1 with distinct data, m_ready=1 → m_block sequence 0,1,2,3,0,…, one packet per cycle, pkt_count=8 after 8 delivered cycles.
- tt collision: ev_valid=4'b1111 and tt_valid pulsed for one cycle when rr_ptr=2 → tt_ready=1 that cycle, next output m_is_tt=1 with m_data=tt, following output m_block=2.
- Backpressure: m_ready=0 for 10 cycles with a held packet → m_* stable, all readies 0. When m_ready rises, the held packet is delivered and the next winner is loaded in the same cycle.
- enable=0 with valids asserted → no readies; the held packet still drains; m_valid=0 afterwards. Re-enable → grant resumes at the retained rr_ptr.
- Counter wrap: force pkt_count to 32'hFFFF_FFFF (via delivered traffic or a bench preload) → the next delivery yields 0.
